// File: rtl/regfile_sweep.sv
// regfile_sweep: parametrised 2R/1W register file with registered reads and a hardware clear sweep
//
// Parameters:
//   WIDTH   data width in bits
//   AWIDTH  address width; DEPTH = 2**AWIDTH entries
//   ZERO_R0 when 1, entry 0 reads as 0 and writes to it are dropped
// Ports:
//   CLK    clock, all state updates on the rising edge
//   RESET  asynchronous active-high reset; clears entries, outputs and the sweeper
//   AA/BA  read addresses for ports A/B
//   DA/DD  write address/data, RW write enable (ignored while BUSY)
//   CLR    clear request level, starts a sweep from IDLE
//   AD/BD  registered read data, one edge of latency
//   BUSY   clear sweep in progress
// Build option:
//   REGFILE_BYPASS_EN  forward a same-edge write to a matching read port
module regfile_sweep #(
  parameter int WIDTH   = 16,
  parameter int AWIDTH  = 3,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [AWIDTH-1:0] AA,
  input  logic [AWIDTH-1:0] BA,
  input  logic [AWIDTH-1:0] DA,
  input  logic [WIDTH-1:0]  DD,
  input  logic              RW,
  input  logic              CLR,
  output logic [WIDTH-1:0]  AD,
  output logic [WIDTH-1:0]  BD,
  output logic              BUSY
);
  localparam int DEPTH = 2**AWIDTH;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t            r_state;
  logic [AWIDTH-1:0] r_cnt;
  logic              r_busy;
  logic [WIDTH-1:0]  r_ad, r_bd;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_we, w_fwd_a, w_fwd_b;
  logic [WIDTH-1:0]  w_rd_a, w_rd_b;
  // writes are blocked while sweeping and silently dropped to a hardwired-zero entry 0
  assign w_we = RW && !r_busy && !(ZERO_R0 && DA == '0);
`ifdef REGFILE_BYPASS_EN
  assign w_fwd_a = w_we && DA == AA;
  assign w_fwd_b = w_we && DA == BA;
`else
  assign w_fwd_a = 1'b0;
  assign w_fwd_b = 1'b0;
`endif
  assign w_rd_a = (ZERO_R0 && AA == '0) ? '0 : w_fwd_a ? DD : r_mem[AA];
  assign w_rd_b = (ZERO_R0 && BA == '0) ? '0 : w_fwd_b ? DD : r_mem[BA];
  assign AD   = r_ad;
  assign BD   = r_bd;
  assign BUSY = r_busy;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_ad    <= '0;
      r_bd    <= '0;
    end else begin
      // reads sample pre-edge contents, so an entry swept this edge still shows its old value
      r_ad <= w_rd_a;
      r_bd <= w_rd_b;
      if (r_state == SWEEP) begin
        r_mem[r_cnt] <= '0;
        r_cnt        <= r_cnt + 1'b1;
        if (&r_cnt) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      end else begin
        if (w_we) r_mem[DA] <= DD;
        if (CLR) begin
          r_state <= SWEEP;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_sweep.sv
// tb_regfile_sweep: scoreboard bench for regfile_sweep (default and ZERO_R0 instances)
module tb_regfile_sweep;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        CLK = 1'b0, RESET = 1'b1, RW = 1'b0, CLR = 1'b0;
  logic [2:0]  AA = '0, BA = '0, DA = '0;
  logic [15:0] DD = '0;
  logic [15:0] AD, BD, AD_z, BD_z;
  logic        BUSY, BUSY_z;
  typedef struct {logic [15:0] ad, bd, zad, zbd; logic busy;} exp_t;
  exp_t        sb[$];
  logic [15:0] m [8];
  logic [15:0] mz [8];
  logic        m_busy;
  int          m_cnt;
  int          n_cmp = 0, n_bad = 0;

  regfile_sweep #(.WIDTH(16), .AWIDTH(3), .ZERO_R0(1'b0)) dut (
    .CLK(CLK), .RESET(RESET), .AA(AA), .BA(BA), .DA(DA), .DD(DD), .RW(RW), .CLR(CLR),
    .AD(AD), .BD(BD), .BUSY(BUSY));
  regfile_sweep #(.WIDTH(16), .AWIDTH(3), .ZERO_R0(1'b1)) dut_z (
    .CLK(CLK), .RESET(RESET), .AA(AA), .BA(BA), .DA(DA), .DD(DD), .RW(RW), .CLR(CLR),
    .AD(AD_z), .BD(BD_z), .BUSY(BUSY_z));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m[i]  = '0;
      mz[i] = '0;
    end
    m_busy = 1'b0;
    m_cnt  = 0;
  endtask

  // drive one cycle of stimulus, predict the post-edge outputs, then compare after the edge
  task automatic step(input logic [2:0] aa, input logic [2:0] ba, input logic [2:0] da,
                      input logic [15:0] dd, input logic rw, input logic clr);
    exp_t e;
    logic fa, fb;
    AA = aa; BA = ba; DA = da; DD = dd; RW = rw; CLR = clr;
    fa = BYP && rw && !m_busy && da == aa;
    fb = BYP && rw && !m_busy && da == ba;
    e.ad  = fa ? dd : m[aa];
    e.bd  = fb ? dd : m[ba];
    e.zad = (aa == 0) ? 16'h0 : fa ? dd : mz[aa];
    e.zbd = (ba == 0) ? 16'h0 : fb ? dd : mz[ba];
    if (m_busy) begin
      m[m_cnt]  = '0;
      mz[m_cnt] = '0;
      if (m_cnt == 7) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end else m_cnt++;
    end else begin
      if (rw) begin
        m[da] = dd;
        if (da != 0) mz[da] = dd;
      end
      if (clr) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
    e.busy = m_busy;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check("ad", AD, e.ad);
    check("bd", BD, e.bd);
    check("busy", BUSY, e.busy);
    check("z_ad", AD_z, e.zad);
    check("z_bd", BD_z, e.zbd);
    check("z_busy", BUSY_z, e.busy);
  endtask

  // asynchronous reset pulse between edges; outputs must clear without a clock
  task automatic pulse_reset(input string tag);
    @(negedge CLK);
    RESET = 1'b1;
    CLR   = 1'b0;
    RW    = 1'b0;
    #1;
    model_reset();
    check({tag, "_ad"}, AD, 16'h0);
    check({tag, "_bd"}, BD, 16'h0);
    check({tag, "_busy"}, BUSY, 1'b0);
    RESET = 1'b0;
  endtask

  initial begin
    int busy_len;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ad", AD, 16'h0);
    check("rst_bd", BD, 16'h0);
    check("rst_busy", BUSY, 1'b0);
    RESET = 1'b0;

    step(0, 0, 5, 16'hBEEF, 1, 0);
    step(5, 5, 0, 16'h0, 0, 0);
    check("r5_before_rst", AD, 16'hBEEF);
    pulse_reset("midrst");
    step(5, 5, 0, 16'h0, 0, 0);
    check("r5_after_rst", AD, 16'h0);

    step(0, 0, 3, 16'h1234, 1, 0);
    step(3, 3, 0, 16'h0, 0, 0);
    check("r3_a", AD, 16'h1234);
    check("r3_b", BD, 16'h1234);
    step(0, 0, 7, 16'hFFFF, 1, 0);
    step(7, 7, 0, 16'h0, 0, 0);
    check("r7_top", AD, 16'hFFFF);

    step(0, 0, 2, 16'h0001, 1, 0);
    step(2, 3, 2, 16'hA5A5, 1, 0);
    check("coll_first", AD, BYP ? 16'hA5A5 : 16'h0001);
    step(2, 2, 0, 16'h0, 0, 0);
    check("coll_next", AD, 16'hA5A5);

    for (int i = 0; i < 8; i++) step(3'(i), 3'(7 - i), 3'(i), 16'(16'h0011 * (i + 1)), 1, 0);
    step(7, 6, 0, 16'h0, 0, 1);
    busy_len = int'(BUSY);
    for (int k = 0; k < 12; k++) begin
      if (k == 2) step(7, 6, 6, 16'h7777, 1, 0);
      else step(7, 6, 0, 16'h0, 0, 0);
      busy_len += int'(BUSY);
    end
    check("busy_len", busy_len, 8);
    for (int i = 0; i < 8; i++) begin
      step(3'(i), 3'(7 - i), 0, 16'h0, 0, 0);
      check("swept", AD, 16'h0);
    end

    for (int i = 0; i < 8; i++) step(0, 0, 3'(i), 16'(16'h0100 + i), 1, 0);
    step(1, 2, 0, 16'h0, 0, 1);
    step(1, 2, 0, 16'h0, 0, 0);
    step(1, 2, 0, 16'h0, 0, 0);
    pulse_reset("sweeprst");
    for (int i = 0; i < 8; i++) begin
      step(3'(i), 3'(i), 0, 16'h0, 0, 0);
      check("abort_data", AD, 16'h0);
      check("abort_busy", BUSY, 1'b0);
    end

    for (int i = 0; i < 8; i++) step(0, 0, 3'(i), 16'(16'h0F00 | i), 1, 0);
    for (int k = 0; k < 10; k++) step(3'(k), 3'(k + 4), 0, 16'h0, 0, 1);
    for (int k = 0; k < 10; k++) step(3'(k), 3'(k + 1), 3'(k), 16'(16'h2000 + k), 1, 0);

    step(0, 0, 0, 16'hFFFF, 1, 0);
    check("z_fwd", AD_z, 16'h0);
    step(0, 0, 0, 16'h0, 0, 0);
    check("z_read", AD_z, 16'h0);
    check("nz_read", AD, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/regfile_sweep.md
# regfile_sweep

Parametrised two-read/one-write register file for the datapath, succeeding the fixed 8×16 register file. Width and depth are parameters, and read data is registered with one cycle of latency. Optional write-to-read forwarding is available. A hardware clear sequencer zeroes every entry on command without a global reset.

## Interface
- WIDTH, 16, data width in bits.
- AWIDTH, 3, address width; DEPTH = 2**AWIDTH entries.
- ZERO_R0, 0, when 1, entry 0 always reads 0 and writes to it are discarded.

- CLK  input  1  clock, all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- AA  input  AWIDTH  read address, port A.
- BA  input  AWIDTH  read address, port B.
- DA  input  AWIDTH  write address.
- DD  input  WIDTH  write data.
- RW  input  1  write enable.
- CLR  input  1  clear request; a level sampled on the rising edge.
- AD  output  WIDTH  registered read data, port A.
- BD  output  WIDTH  registered read data, port B.
- BUSY  output  1  clear sweep in progress.

## Operation
- Storage: DEPTH × WIDTH flops, with no memory macro.
- Write: the write happens at the edge when RW=1 and BUSY=0.
  - R[DA] <= DD.
  - When ZERO_R0=1 and DA=0, the write is dropped.
- Read:
  - At every edge, AD <= R[AA] and BD <= R[BA], regardless of RW and BUSY.
  - With ZERO_R0=1, address 0 returns 0.
- States: IDLE and SWEEP, with a counter CNT of AWIDTH bits.
- IDLE → SWEEP happens on an edge where CLR=1.
  - CNT <= 0 and BUSY <= 1.
  - A write with RW=1 at that same edge still completes.
- SWEEP:
  - Each edge performs R[CNT] <= 0 and CNT <= CNT+1.
  - At CNT = DEPTH-1, the FSM clears that entry, returns to IDLE, sets BUSY <= 0 and CNT <= 0.
- During SWEEP:
  - RW is ignored (the write is lost, not queued).
  - CLR is ignored.
  - Reads return current contents: already-swept entries read 0, unswept entries keep their old value.
- Same-edge read of the entry being swept returns its pre-clear value.
- Reset:
  - Asserting RESET at any time, including mid-sweep, forces all entries, AD, BD, CNT and BUSY to 0 and the FSM to IDLE.
  - An aborted sweep is not resumed.

## Timing
- Read latency: AD/BD reflect the address presented one edge earlier.
- Write-to-read latency: 1 edge with forwarding, 2 edges without it.
- BUSY rises at the edge after CLR is sampled and stays high for exactly DEPTH cycles. BUSY=0 at the edge after the last entry is cleared.
- Back-to-back CLR: CLR held high through the sweep has no effect while BUSY=1. If CLR is still high at the first IDLE edge, a new sweep starts there.
- Outputs after reset: AD=0, BD=0, BUSY=0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - At an edge with RW=1, BUSY=0 and DA==AA, AD <= DD instead of the stale R[AA]. The same rule applies to BA/BD.
  - No forwarding when ZERO_R0=1 and DA=0; 0 is returned.
  - No forwarding during SWEEP.
- REGFILE_BYPASS_EN undefined: AD/BD carry the pre-write contents in that case. The new value is visible one edge later.

## Test plan
- Reset:
  - Write 16'hBEEF to R5, then pulse RESET mid-cycle.
  - Expect AD=BD=0 immediately.
  - AA=5 then reads 0 one edge later.
- Basic write/read:
  - RW=1, DA=3, DD=16'h1234; next cycle AA=3, BA=3.
  - Expect AD=BD=16'h1234 one edge later.
  - With defaults, also write R7=16'hFFFF and read it back, checking the top address.
- Same-cycle collision:
  - RW=1, DA=AA=2, DD=16'hA5A5, with R2 previously 16'h0001.
  - Macro defined: expect AD=16'hA5A5 after that edge.
  - Macro undefined: expect AD=16'h0001, then 16'hA5A5 on the following edge.
- Clear sweep:
  - Fill R0..R7 with 16'h0011·(i+1), then pulse CLR for one cycle.
  - Expect BUSY high for exactly 8 cycles, with all entries reading 0 afterwards.
  - RW=1, DA=6, DD=16'h7777 issued mid-sweep is lost, so R6 reads 0.
- Reset mid-sweep:
  - Assert RESET at sweep cycle 3.
  - Expect BUSY=0 immediately and all entries 0.
  - CLR low afterwards: no sweep restarts.
- ZERO_R0=1 build:
  - Write DA=0, DD=16'hFFFF.
  - Expect AA=0 to read 0, including the forwarding case.
